// File: rtl/t_trit_pkg.sv
// t_trit_pkg
//   Shared ternary definitions for the trit serializer, the DLFET inverter
//   stage and later ternary gates. Trits are 2-bit binary coded:
//   00 = 0, 01 = 1, 10 = 2, 11 = illegal.
//   Contents:
//     TRIT_0/1/2/BAD    trit code constants
//     ST_IDLE/SHIFT/PARITY  serializer FSM encodings
//     trit_sanitize     maps the illegal code 11 onto 01
//     trit_add_mod3     mod-3 sum of two legal trits
//   Optional feature macro used by clients: TRIT_PARITY_EN.
package t_trit_pkg;

  localparam logic [1:0] TRIT_0   = 2'b00;
  localparam logic [1:0] TRIT_1   = 2'b01;
  localparam logic [1:0] TRIT_2   = 2'b10;
  localparam logic [1:0] TRIT_BAD = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;

  // The inverter must never see 11, so an illegal code is forced to state 1.
  function automatic logic [1:0] trit_sanitize(input logic [1:0] t);
    return (t == TRIT_BAD) ? TRIT_1 : t;
  endfunction

  // Operands are assumed legal (0..2), so the raw sum is at most 4 and one
  // conditional subtraction of 3 is enough.
  function automatic logic [1:0] trit_add_mod3(input logic [1:0] a,
                                               input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/t_trit_serializer_mod3_acc.sv
// t_trit_mod3_acc
//   Running mod-3 sum of a trit stream. Used by the serializer to build the
//   parity trit when TRIT_PARITY_EN is defined.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst    asynchronous active-high reset, clears the sum
//     i_clear  synchronous clear (start of a new word)
//     i_en     add i_trit into the sum this cycle
//     i_trit   legal trit to accumulate
//     o_sum    current sum mod 3
module t_trit_mod3_acc
  import t_trit_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clear,
  input  logic       i_en,
  input  logic [1:0] i_trit,
  output logic [1:0] o_sum
);

  logic [1:0] r_sum;

  // Clear wins over accumulate: a load and a beat never coincide in the
  // serializer, but clear-first keeps the block safe on its own.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sum <= TRIT_0;
    end else if (i_clear) begin
      r_sum <= TRIT_0;
    end else if (i_en) begin
      r_sum <= trit_add_mod3(r_sum, i_trit);
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/t_trit_serializer.sv
// t_trit_serializer
//   Upstream feeder for the ternary DLFET inverter. Takes an N_TRITS-wide
//   parallel word over valid/ready and streams it out one trit per accepted
//   beat, LSB trit first. Illegal 11 trits are replaced with 01 on load and
//   flagged on the sticky err output.
//   Optional feature: TRIT_PARITY_EN appends a mod-3 parity trit per word.
//   Ports:
//     i_clk          clock, rising edge
//     i_rst          asynchronous active-high reset
//     i_in_word      parallel word, trit k at bits [2k+1:2k]
//     i_in_valid     word is valid
//     o_in_ready     serializer can take a word (IDLE, not in reset)
//     o_trit_out     current trit, never 11
//     o_trit_valid   o_trit_out holds a valid trit
//     i_trit_ready   downstream takes o_trit_out this cycle
//     o_trit_last    final beat of the word
//     o_err          sticky illegal-trit flag
//     i_err_clr      synchronous clear of o_err
module t_trit_serializer
  import t_trit_pkg::*;
#(
  parameter int N_TRITS = 9
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [2*N_TRITS-1:0] i_in_word,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [1:0]           o_trit_out,
  output logic                 o_trit_valid,
  input  logic                 i_trit_ready,
  output logic                 o_trit_last,
  output logic                 o_err,
  input  logic                 i_err_clr
);

  localparam int CNT_W = $clog2(N_TRITS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_TRITS - 1);

  logic [1:0]           r_state;
  logic [2*N_TRITS-1:0] r_shreg;
  logic [CNT_W-1:0]     r_idx;
  logic                 r_err;

  logic [2*N_TRITS-1:0] w_san_word;
  logic                 w_any_bad;
  logic                 w_load;
  logic                 w_beat;
  logic                 w_last_idx;

  // Sanitise every trit of the incoming word and note whether any was 11.
  always_comb begin
    w_san_word = '0;
    w_any_bad  = 1'b0;
    for (int k = 0; k < N_TRITS; k++) begin
      w_san_word[2*k +: 2] = trit_sanitize(i_in_word[2*k +: 2]);
      if (i_in_word[2*k +: 2] == TRIT_BAD) w_any_bad = 1'b1;
    end
  end

  // in_ready is gated by reset so nothing is accepted while rst is held.
  assign o_in_ready   = (r_state == ST_IDLE) && !i_rst;
  assign o_trit_valid = (r_state != ST_IDLE);
  assign w_load       = i_in_valid && o_in_ready;
  assign w_beat       = o_trit_valid && i_trit_ready;
  assign w_last_idx   = (r_idx == LAST_IDX);

`ifdef TRIT_PARITY_EN
  logic [1:0] w_parity;

  // Sum the sanitised data trits as they leave; cleared by each load.
  t_trit_mod3_acc u_acc (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (w_load),
    .i_en    (w_beat && (r_state == ST_SHIFT)),
    .i_trit  (r_shreg[1:0]),
    .o_sum   (w_parity)
  );

  assign o_trit_last = (r_state == ST_PARITY);
`else
  assign o_trit_last = (r_state == ST_SHIFT) && w_last_idx;
`endif

  // Output trit comes straight from state, so it holds during stalls and
  // drops to 00 the instant reset asserts.
  always_comb begin
    o_trit_out = TRIT_0;
    case (r_state)
      ST_SHIFT:  o_trit_out = r_shreg[1:0];
`ifdef TRIT_PARITY_EN
      ST_PARITY: o_trit_out = w_parity;
`endif
      default:   o_trit_out = TRIT_0;
    endcase
  end

  // Main FSM with shift register and trit index. in_word is only sampled in
  // IDLE, so in_valid during a word is simply ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_shreg <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_load) begin
            r_shreg <= w_san_word;
            r_idx   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_beat) begin
            r_shreg <= r_shreg >> 2;
            r_idx   <= r_idx + CNT_W'(1);
            if (w_last_idx) begin
              r_idx <= '0;
`ifdef TRIT_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_IDLE;
`endif
            end
          end
        end
`ifdef TRIT_PARITY_EN
        ST_PARITY: begin
          if (w_beat) r_state <= ST_IDLE;
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky error: a set on the load edge beats a coincident clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_err <= 1'b0;
    end else if (w_load && w_any_bad) begin
      r_err <= 1'b1;
    end else if (i_err_clr) begin
      r_err <= 1'b0;
    end
  end

  assign o_err = r_err;

endmodule

// File: tb/tb_t_trit_serializer.sv
// tb_t_trit_serializer
//   Directed bench for t_trit_serializer with N_TRITS = 9. Inputs are driven
//   and outputs sampled on the falling clock edge. Build with TRIT_PARITY_EN
//   defined to include the parity scenario.
module tb_t_trit_serializer;

  localparam int N = 9;
`ifdef TRIT_PARITY_EN
  localparam int BEATS = N + 1;
`else
  localparam int BEATS = N;
`endif

  // Trits 8..0 = 2,1,0,2,1,0,2,1,0 -> emitted 0,1,2,0,1,2,0,1,2
  localparam logic [17:0] W_SEQ  = 18'h24924;
  // All trits 1
  localparam logic [17:0] W_ONES = 18'h15555;
  // All trits 2
  localparam logic [17:0] W_TWOS = 18'h2AAAA;
  // Only trit3 = 11
  localparam logic [17:0] W_BAD3 = 18'h000C0;
  // All trits 2 except trit3 = 11
  localparam logic [17:0] W_MIXB = 18'h2AAEA;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] inWord = '0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [1:0]  tritOut;
  logic        tritValid;
  logic        tritReady = 1'b0;
  logic        tritLast;
  logic        err;
  logic        errClr = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  t_trit_serializer #(.N_TRITS(N)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_word    (inWord),
    .i_in_valid   (inValid),
    .o_in_ready   (inReady),
    .o_trit_out   (tritOut),
    .o_trit_valid (tritValid),
    .i_trit_ready (tritReady),
    .o_trit_last  (tritLast),
    .o_err        (err),
    .i_err_clr    (errClr)
  );

  always #5 clk = ~clk;

  // Reference beat k of word w: data trit k with 11 shown as 01, or for
  // k == 9 the mod-3 sum of those sanitised trits.
  function automatic logic [1:0] expBeat(input logic [17:0] w, input int k);
    logic [1:0] t;
    int sum;
    sum = 0;
    if (k < N) begin
      t = w[2*k +: 2];
      return (t == 2'b11) ? 2'b01 : t;
    end
    for (int i = 0; i < N; i++) begin
      t = w[2*i +: 2];
      if (t == 2'b11) t = 2'b01;
      sum += int'(t);
    end
    return 2'(sum % 3);
  endfunction

  // One-cycle load pulse from IDLE; returns at the falling edge where the
  // first beat is visible.
  task automatic loadWord(input logic [17:0] w, input logic clr);
    inWord  = w;
    inValid = 1'b1;
    errClr  = clr;
    @(negedge clk);
    inValid = 1'b0;
    errClr  = 1'b0;
  endtask

  task automatic drainWord();
    tritReady = 1'b1;
    repeat (BEATS) @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if (inReady !== 1'b0 || tritValid !== 1'b0 || tritOut !== 2'b00 ||
        tritLast !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: rdy=%b vld=%b out=%b last=%b err=%b, want 0 0 00 0 0",
               inReady, tritValid, tritOut, tritLast, err);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_release_ready: got %b want 1", inReady);
    end
    // Reset in the middle of a word that has set err
    tritReady = 1'b1;
    loadWord(W_MIXB, 1'b0);
    repeat (2) @(negedge clk);
    vectors++;
    if (tritValid !== 1'b1 || tritOut !== 2'b10 || err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_midword: vld=%b out=%b err=%b, want 1 10 1",
               tritValid, tritOut, err);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (tritValid !== 1'b0 || tritOut !== 2'b00 || err !== 1'b0 || inReady !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_midword: vld=%b out=%b err=%b rdy=%b, want 0 00 0 0",
               tritValid, tritOut, err, inReady);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (inReady !== 1'b1 || tritValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_recover: rdy=%b vld=%b, want 1 0", inReady, tritValid);
    end
  endtask

  task automatic test_stream();
    tritReady = 1'b1;
    loadWord(W_SEQ, 1'b0);
    for (int k = 0; k < BEATS; k++) begin
      vectors++;
      if (tritValid !== 1'b1 || tritOut !== expBeat(W_SEQ, k) ||
          tritLast !== (k == BEATS - 1)) begin
        miscompares++;
        $display("[TB] FAIL stream_beat%0d: vld=%b out=%b last=%b, want 1 %b %b",
                 k, tritValid, tritOut, tritLast, expBeat(W_SEQ, k), (k == BEATS - 1));
      end
      @(negedge clk);
    end
    vectors++;
    if (tritValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL stream_idle: vld=%b rdy=%b, want 0 1", tritValid, inReady);
    end
  endtask

  task automatic test_backpressure();
    loadWord(W_SEQ, 1'b0);
    for (int c = 0; c < 2 * BEATS; c++) begin
      tritReady = c[0];
      vectors++;
      if (tritValid !== 1'b1 || tritOut !== expBeat(W_SEQ, c / 2) ||
          tritLast !== (c / 2 == BEATS - 1)) begin
        miscompares++;
        $display("[TB] FAIL bp_cycle%0d: vld=%b out=%b last=%b, want 1 %b %b",
                 c, tritValid, tritOut, tritLast, expBeat(W_SEQ, c / 2), (c / 2 == BEATS - 1));
      end
      @(negedge clk);
    end
    tritReady = 1'b1;
    vectors++;
    if (tritValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL bp_idle: vld=%b rdy=%b, want 0 1", tritValid, inReady);
    end
  endtask

  task automatic test_illegal();
    tritReady = 1'b1;
    loadWord(W_BAD3, 1'b0);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL illegal_err_set: got %b want 1", err);
    end
    for (int k = 0; k < BEATS; k++) begin
      vectors++;
      if (tritOut !== expBeat(W_BAD3, k)) begin
        miscompares++;
        $display("[TB] FAIL illegal_beat%0d: got %b want %b", k, tritOut, expBeat(W_BAD3, k));
      end
      @(negedge clk);
    end
    // Clean word with err_clr clears the flag
    loadWord(18'h00000, 1'b1);
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_err_clr: got %b want 0", err);
    end
    drainWord();
    loadWord(W_BAD3, 1'b0);
    drainWord();
    // err_clr together with another illegal load: set wins
    loadWord(W_BAD3, 1'b1);
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL illegal_set_priority: got %b want 1", err);
    end
    drainWord();
    errClr = 1'b1;
    @(negedge clk);
    errClr = 1'b0;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL illegal_idle_clr: got %b want 0", err);
    end
  endtask

  task automatic test_valid_ignored();
    tritReady = 1'b1;
    inWord  = W_SEQ;
    inValid = 1'b1;
    @(negedge clk);
    for (int k = 0; k < BEATS; k++) begin
      inWord = 18'($urandom);
      vectors++;
      if (inReady !== 1'b0 || tritOut !== expBeat(W_SEQ, k)) begin
        miscompares++;
        $display("[TB] FAIL ignore_beat%0d: rdy=%b out=%b, want 0 %b",
                 k, inReady, tritOut, expBeat(W_SEQ, k));
      end
      @(negedge clk);
    end
    inWord = W_ONES;
    vectors++;
    if (inReady !== 1'b1 || tritValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_idle: rdy=%b vld=%b, want 1 0", inReady, tritValid);
    end
    @(negedge clk);
    inValid = 1'b0;
    vectors++;
    if (tritValid !== 1'b1 || tritOut !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL ignore_second_word: vld=%b out=%b, want 1 01", tritValid, tritOut);
    end
    drainWord();
    vectors++;
    if (tritValid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ignore_drain: vld=%b want 0", tritValid);
    end
  endtask

`ifdef TRIT_PARITY_EN
  task automatic test_parity();
    tritReady = 1'b1;
    loadWord(W_TWOS, 1'b0);
    for (int k = 0; k < N; k++) begin
      vectors++;
      if (tritOut !== 2'b10 || tritLast !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL parity_data%0d: out=%b last=%b, want 10 0", k, tritOut, tritLast);
      end
      @(negedge clk);
    end
    vectors++;
    if (tritValid !== 1'b1 || tritOut !== 2'b00 || tritLast !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_beat: vld=%b out=%b last=%b, want 1 00 1",
               tritValid, tritOut, tritLast);
    end
    @(negedge clk);
    vectors++;
    if (tritValid !== 1'b0 || inReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL parity_idle: vld=%b rdy=%b, want 0 1", tritValid, inReady);
    end
  endtask
`endif

  initial begin
    $display("[TB] start, N_TRITS=%0d beats/word=%0d", N, BEATS);
    test_reset();
    test_stream();
    test_backpressure();
    test_illegal();
    test_valid_ignored();
`ifdef TRIT_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
